// File: rtl/alu_pkg.sv
// Shared opcodes, widths, saturation constants and result payload for the WISC execute-stage ALU.
package alu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned OP_W  = 4;
    localparam int unsigned RED_W = 7;

    localparam logic [OP_W-1:0] OP_ADD    = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'h1;
    localparam logic [OP_W-1:0] OP_XOR    = 4'h2;
    localparam logic [OP_W-1:0] OP_RED    = 4'h3;
    localparam logic [OP_W-1:0] OP_SLL    = 4'h4;
    localparam logic [OP_W-1:0] OP_SRA    = 4'h5;
    localparam logic [OP_W-1:0] OP_ROR    = 4'h6;
    localparam logic [OP_W-1:0] OP_PADDSB = 4'h7;
    localparam logic [OP_W-1:0] OP_LW     = 4'h8;
    localparam logic [OP_W-1:0] OP_SW     = 4'h9;
    localparam logic [OP_W-1:0] OP_LLB    = 4'hA;
    localparam logic [OP_W-1:0] OP_LHB    = 4'hB;

    localparam logic [WIDTH-1:0] SAT_POS16 = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG16 = 16'h8000;
    localparam logic [NIB_W-1:0] SAT_POS4  = 4'h7;
    localparam logic [NIB_W-1:0] SAT_NEG4  = 4'h8;

    typedef struct packed {
        logic [WIDTH-1:0] value;
        logic             ovf;
        logic             illegal;
    } alu_res_t;

    // Sign-extend a nibble to the reduction-sum width.
    function automatic logic [RED_W-1:0] nib_sext(input logic [NIB_W-1:0] n);
        return {{(RED_W-NIB_W){n[NIB_W-1]}}, n};
    endfunction

endpackage

// File: rtl/alu16_regd_if.sv
// Issue/result bundle between the decode stage and the execute-stage ALU.
interface alu16_regd_if;
    import alu_pkg::*;

    logic              in_valid;
    logic [OP_W-1:0]   alu_code;
    logic [WIDTH-1:0]  rs;
    logic [WIDTH-1:0]  rt;
    logic              out_valid;
    logic [WIDTH-1:0]  alu_out;
    logic              ovf_flag;
    logic              zero_flag;
    logic              illegal;

    modport master (
        output in_valid, alu_code, rs, rt,
        input  out_valid, alu_out, ovf_flag, zero_flag, illegal
    );

    modport slave (
        input  in_valid, alu_code, rs, rt,
        output out_valid, alu_out, ovf_flag, zero_flag, illegal
    );
endinterface

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice exporting group G/P; optionally saturates its own nibble (PADDSB).
module cla4_slice
    import alu_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    input  logic             sat4,
    output logic [NIB_W-1:0] sum,
    output logic             grp_g,
    output logic             grp_p
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;
    logic             ovf4;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
        c[4]  = grp_g | (grp_p & cin);

        // Signed nibble overflow: carry into MSB differs from carry out.
        ovf4 = c[3] ^ c[4];

        sum = p ^ c[NIB_W-1:0];
        if (sat4 && ovf4) begin
            sum = a[NIB_W-1] ? SAT_NEG4 : SAT_POS4;
        end
    end

endmodule

// File: rtl/alu16_regd.sv
// 16-bit WISC execute-stage ALU: CLA adder with saturation, barrel shifter, nibble reduction; 1-cycle registered result.
module alu16_regd
    import alu_pkg::*;
(
    input logic         clk,
    input logic         rst,
    alu16_regd_if.slave bus
);

    logic [WIDTH-1:0] a_c;
    logic [WIDTH-1:0] b_c;
    logic             cin_c;
    logic             sat4_c;
    logic [3:0]       slice_cin;
    logic [3:0]       gg;
    logic [3:0]       gp;
    logic [WIDTH-1:0] sum_c;
    logic             c16_c;
    logic             c15_c;
    logic             add_ovf_c;
    logic [WIDTH-1:0] add_sat_c;
    logic [RED_W-1:0] red_c;
    logic [3:0]       amt_c;
    logic [WIDTH-1:0] sll_c;
    logic [WIDTH-1:0] sra_c;
    logic [2*WIDTH-1:0] ror_wide_c;
    logic             is_mem_c;
    alu_res_t         res_c;

    // Adder operand selection: SUB inverts rt, LW/SW form the word-aligned address.
    always_comb begin
        is_mem_c = (bus.alu_code == OP_LW) || (bus.alu_code == OP_SW);
        sat4_c   = (bus.alu_code == OP_PADDSB);
        cin_c    = (bus.alu_code == OP_SUB);
        a_c      = is_mem_c ? (bus.rs & 16'hFFFE) : bus.rs;
        if (bus.alu_code == OP_SUB) begin
            b_c = ~bus.rt;
        end else if (is_mem_c) begin
            b_c = {bus.rt[WIDTH-2:0], 1'b0};
        end else begin
            b_c = bus.rt;
        end
    end

    // Lookahead carry unit; PADDSB isolates the nibbles.
    always_comb begin
        slice_cin[0] = cin_c;
        slice_cin[1] = ~sat4_c & (gg[0] | (gp[0] & cin_c));
        slice_cin[2] = ~sat4_c & (gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin_c));
        slice_cin[3] = ~sat4_c & (gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                                 | (gp[2] & gp[1] & gp[0] & cin_c));
        c16_c = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & cin_c);
    end

    for (genvar i = 0; i < 4; i++) begin : g_slice
        cla4_slice u_slice (
            .a     (a_c[NIB_W*i +: NIB_W]),
            .b     (b_c[NIB_W*i +: NIB_W]),
            .cin   (slice_cin[i]),
            .sat4  (sat4_c),
            .sum   (sum_c[NIB_W*i +: NIB_W]),
            .grp_g (gg[i]),
            .grp_p (gp[i])
        );
    end

    // Carry into bit 15 is recovered from the unsaturated sum bit.
    always_comb begin
        c15_c     = sum_c[WIDTH-1] ^ a_c[WIDTH-1] ^ b_c[WIDTH-1];
        add_ovf_c = c15_c ^ c16_c;
        add_sat_c = add_ovf_c ? (a_c[WIDTH-1] ? SAT_NEG16 : SAT_POS16) : sum_c;
    end

    always_comb begin
        red_c = '0;
        for (int i = 0; i < 4; i++) begin
            red_c = red_c + nib_sext(bus.rs[NIB_W*i +: NIB_W]) + nib_sext(bus.rt[NIB_W*i +: NIB_W]);
        end
    end

    always_comb begin
        amt_c      = bus.rt[3:0];
        sll_c      = bus.rs << amt_c;
        sra_c      = WIDTH'($signed(bus.rs) >>> amt_c);
        ror_wide_c = {bus.rs, bus.rs} >> amt_c;
    end

    // Opcode decode and result select.
    always_comb begin
        res_c.value   = '0;
        res_c.ovf     = 1'b0;
        res_c.illegal = 1'b0;
        case (bus.alu_code)
            OP_ADD, OP_SUB: begin
                res_c.value = add_sat_c;
                res_c.ovf   = add_ovf_c;
            end
            OP_XOR:          res_c.value = bus.rs ^ bus.rt;
            OP_RED:          res_c.value = {{(WIDTH-RED_W){red_c[RED_W-1]}}, red_c};
            OP_SLL:          res_c.value = sll_c;
            OP_SRA:          res_c.value = sra_c;
            OP_ROR:          res_c.value = ror_wide_c[WIDTH-1:0];
            OP_PADDSB:       res_c.value = sum_c;
            OP_LW, OP_SW:    res_c.value = sum_c;
            OP_LLB:          res_c.value = {bus.rs[15:8], bus.rt[7:0]};
            OP_LHB:          res_c.value = {bus.rt[7:0], bus.rs[7:0]};
            default:         res_c.illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.alu_out   <= '0;
            bus.ovf_flag  <= 1'b0;
            bus.zero_flag <= 1'b0;
            bus.illegal   <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.alu_out   <= res_c.value;
                bus.ovf_flag  <= res_c.ovf;
                bus.zero_flag <= (res_c.value == '0);
                bus.illegal   <= res_c.illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu16_regd.sv
// Directed bench for alu16_regd: hand-computed vectors checked one cycle after issue.
module tb_alu16_regd;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu16_regd_if bus ();

    alu16_regd dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = v;
        bus.alu_code = op;
        bus.rs       = a;
        bus.rt       = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] exp_out, input logic exp_ovf,
                           input logic exp_zero, input logic exp_ill, input logic exp_valid);
        chk({tag, ".out"},   bus.alu_out, exp_out);
        chk({tag, ".ovf"},   {15'b0, bus.ovf_flag},  {15'b0, exp_ovf});
        chk({tag, ".zero"},  {15'b0, bus.zero_flag}, {15'b0, exp_zero});
        chk({tag, ".ill"},   {15'b0, bus.illegal},   {15'b0, exp_ill});
        chk({tag, ".valid"}, {15'b0, bus.out_valid}, {15'b0, exp_valid});
    endtask

    initial begin
        clk    = 1'b0;
        checks = 0;
        errors = 0;

        // Reset wins over a simultaneous valid issue.
        rst = 1'b1;
        drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001);
        step();
        step();
        chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001); step();
        chk_all("add_satpos", 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_ADD, 16'h8000, 16'hFFFF); step();
        chk_all("add_satneg", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_SUB, 16'h8000, 16'h0001); step();
        chk_all("sub_satneg", 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_SUB, 16'h0005, 16'h0005); step();
        chk_all("sub_zero", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, OP_XOR, 16'h00FF, 16'h0F0F); step();
        chk_all("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_PADDSB, 16'h7878, 16'h1111); step();
        chk_all("paddsb_pos", 16'h7979, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_PADDSB, 16'h8888, 16'h8888); step();
        chk_all("paddsb_neg", 16'h8888, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_SLL, 16'h0001, 16'h000F); step();
        chk_all("sll15", 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_SRA, 16'h8000, 16'h0004); step();
        chk_all("sra4", 16'hF800, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_ROR, 16'h0001, 16'h0001); step();
        chk_all("ror1", 16'h8000, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_SRA, 16'h1234, 16'h0010); step();
        chk_all("sra0", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_ROR, 16'h8421, 16'h0004); step();
        chk_all("ror4", 16'h1842, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_RED, 16'h7777, 16'h7777); step();
        chk_all("red_max", 16'h0038, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_RED, 16'h8888, 16'h8888); step();
        chk_all("red_min", 16'hFFC0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_LW, 16'h1001, 16'h0003); step();
        chk_all("lw", 16'h1006, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_SW, 16'hFFFF, 16'h8000); step();
        chk_all("sw_wrap", 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_LLB, 16'h1234, 16'h00AB); step();
        chk_all("llb", 16'h12AB, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_LHB, 16'h1234, 16'h00AB); step();
        chk_all("lhb", 16'hAB34, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'hF, 16'h1234, 16'h5678); step();
        chk_all("illegal", 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1);

        // Back-to-back issue: each result lands one cycle after its operands.
        drive(1'b1, OP_ADD, 16'h0001, 16'h0002); step();
        chk_all("pipe0", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_XOR, 16'hF0F0, 16'h0F0F); step();
        chk_all("pipe1", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, OP_LLB, 16'h1234, 16'h0056); step();
        chk_all("pipe2", 16'h1256, 1'b0, 1'b0, 1'b0, 1'b1);

        // Idle cycle: only out_valid drops, result and flags hold.
        drive(1'b0, OP_SUB, 16'h0005, 16'h0005); step();
        chk_all("hold", 16'h1256, 1'b0, 1'b0, 1'b0, 1'b0);

        drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001); step();
        chk_all("pre_rst", 16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b1, OP_ADD, 16'h7FFF, 16'h0001); step();
        chk_all("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, OP_ADD, 16'h0000, 16'h0000); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
